// File: rtl/minterm_encoder16.sv
// Sequential 16-to-4 minterm encoder: accepts a minterm vector and serially emits
// the 4-bit index of every set bit, lowest index first, over a ready/valid stream.
module minterm_encoder16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] min,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [4:0]  count,
    output logic        empty_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic [4:0]  count_q, count_d;
    logic        empty_err_q, empty_err_d;

    logic [3:0]  idx_s;
    logic        one_left_s;
    logic        emit_s;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Bit 0 wins: scan from the top so the lowest set bit is written last.
    function automatic logic [3:0] lowest_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Decode of the pending vector: current index and whether it is the final one.
    always_comb begin
        idx_s      = lowest_index(pend_q);
        one_left_s = (pend_q != 16'h0000) && ((pend_q & (pend_q - 16'h0001)) == 16'h0000);
        emit_s     = (state_q == ST_EMIT);
    end

    // Next-state logic for the accept/emit sequence.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        count_d     = count_q;
        empty_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    pend_d  = min;
                    count_d = popcount16(min);
                    if (min != 16'h0000) begin
                        state_d = ST_EMIT;
                    end else begin
                        empty_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    // Clearing the lowest set bit retires the beat being presented.
                    pend_d = pend_q & (pend_q - 16'h0001);
                    if (one_left_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 16'h0000;
            end
        endcase
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= 16'h0000;
            count_q     <= 5'd0;
            empty_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            count_q     <= count_d;
            empty_err_q <= empty_err_d;
        end
    end

    // Output decode, purely from registered state.
    always_comb begin
        in_ready  = ~emit_s;
        out_valid = emit_s;
        count     = count_q;
        empty_err = empty_err_q;
        if (emit_s) begin
            {a, b, c, d} = idx_s;
            out_last     = one_left_s;
        end else begin
            {a, b, c, d} = 4'd0;
            out_last     = 1'b0;
        end
    end

endmodule
